// File: rtl/line_clear_ctrl_if.sv
// line_clear_ctrl_if: handshake and grid bus between the game FSM, the stored-array register
// and line_clear_ctrl.
//
// Optional macro LINE_CLEAR_SCORE_EN adds the score_o signal.
//
// Signals:
//   start_i          game FSM -> ctrl  one-cycle start pulse; grid_i valid
//   new_game_i       game FSM -> ctrl  clear totals, abort any sequence
//   grid_i           store    -> ctrl  22 x COLS merged grid snapshot
//   grid_o           ctrl -> store     compacted grid, zero unless grid_we_o
//   grid_we_o        ctrl -> store     one-cycle write-back strobe
//   done_o           ctrl -> game FSM  one-cycle completion pulse
//   busy_o           ctrl -> game FSM  sequence in progress
//   lines_cleared_o  ctrl -> game FSM  rows cleared by the last sequence
//   total_lines_o    ctrl -> game FSM  saturating running total
//   score_o          ctrl -> game FSM  saturating score (LINE_CLEAR_SCORE_EN only)
interface line_clear_ctrl_if #(
    parameter int unsigned COLS  = 10,
    parameter int unsigned TOT_W = 16
);
    logic                   start_i;
    logic                   new_game_i;
    logic [21:0][COLS-1:0]  grid_i;
    logic [21:0][COLS-1:0]  grid_o;
    logic                   grid_we_o;
    logic                   done_o;
    logic                   busy_o;
    logic [4:0]             lines_cleared_o;
    logic [TOT_W-1:0]       total_lines_o;
`ifdef LINE_CLEAR_SCORE_EN
    logic [19:0]            score_o;

    modport master (
        output start_i, new_game_i, grid_i,
        input  grid_o, grid_we_o, done_o, busy_o, lines_cleared_o, total_lines_o, score_o
    );

    modport slave (
        input  start_i, new_game_i, grid_i,
        output grid_o, grid_we_o, done_o, busy_o, lines_cleared_o, total_lines_o, score_o
    );
`else
    modport master (
        output start_i, new_game_i, grid_i,
        input  grid_o, grid_we_o, done_o, busy_o, lines_cleared_o, total_lines_o
    );

    modport slave (
        input  start_i, new_game_i, grid_i,
        output grid_o, grid_we_o, done_o, busy_o, lines_cleared_o, total_lines_o
    );
`endif
endinterface

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: line-clear sequencer for the permanent playfield grid.
//
// On an accepted start the merged grid is snapshotted into a work copy. The visible rows
// (0 = top .. ROWS-1 = bottom) are scanned bottom-up one row per cycle; each full row is
// removed by shifting every row above it down by one, and the same row index is rescanned.
// When row 0 has been passed the compacted grid is written back with a single strobe and
// the cleared-line count is folded into a saturating running total. Rows ROWS..21 are
// carried through from the snapshot untouched.
//
// Optional macro LINE_CLEAR_SCORE_EN adds a saturating 20-bit score (bus.score_o).
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    line_clear_ctrl_if.slave: start/new-game handshake, grid in/out, status
module line_clear_ctrl #(
    parameter int unsigned ROWS  = 20,
    parameter int unsigned COLS  = 10,
    parameter int unsigned TOT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    line_clear_ctrl_if.slave  bus
);

    // Wide enough to hold total + 20 without wrapping even for small TOT_W.
    localparam int unsigned SUM_W = ((TOT_W > 5) ? TOT_W : 5) + 1;
    localparam logic [SUM_W-1:0] TotMax = SUM_W'((64'd1 << TOT_W) - 64'd1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StShift,
        StWrite
    } state_e;

    state_e                 state_q, state_d;
    logic [21:0][COLS-1:0]  work_q, work_d;
    logic [4:0]             ptr_q, ptr_d;
    logic [4:0]             count_q, count_d;
    logic [4:0]             lines_q, lines_d;
    logic [TOT_W-1:0]       total_q, total_d;

    logic                   row_full;
    logic                   write_fire;
    logic [SUM_W-1:0]       total_sum;
    logic [TOT_W-1:0]       total_sat;

    assign row_full  = &work_q[ptr_q];
    assign total_sum = SUM_W'(total_q) + SUM_W'(count_q);
    assign total_sat = (total_sum > TotMax) ? '1 : total_sum[TOT_W-1:0];

`ifdef LINE_CLEAR_SCORE_EN
    logic [19:0] score_q, score_d;
    logic [20:0] score_sum;
    logic [19:0] score_sat;

    function automatic logic [10:0] points(input logic [4:0] n);
        logic [10:0] p;
        unique case (n)
            5'd0:    p = 11'd0;
            5'd1:    p = 11'd40;
            5'd2:    p = 11'd100;
            5'd3:    p = 11'd300;
            default: p = 11'd1200;
        endcase
        return p;
    endfunction

    assign score_sum = {1'b0, score_q} + 21'(points(count_q));
    assign score_sat = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start_i) state_d = StScan;
            end
            StScan: begin
                if (row_full) begin
                    state_d = StShift;
                end else if (ptr_q == 5'd0) begin
                    state_d = StWrite;
                end
            end
            StShift: state_d = StScan;
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // new_game outranks everything, including a start in the same cycle.
        if (bus.new_game_i) state_d = StIdle;
    end

    // ------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------
    always_comb begin
        // A new_game arriving in the WRITE cycle suppresses the write-back.
        write_fire          = (state_q == StWrite) && !bus.new_game_i;
        bus.grid_we_o       = write_fire;
        bus.done_o          = write_fire;
        bus.grid_o          = write_fire ? work_q : '0;
        bus.busy_o          = (state_q != StIdle);
        bus.lines_cleared_o = lines_q;
        bus.total_lines_o   = total_q;
`ifdef LINE_CLEAR_SCORE_EN
        bus.score_o         = score_q;
`endif
    end

    // ------------------------------------------------------------------
    // Datapath next-state: work grid, scan pointer, counters
    // ------------------------------------------------------------------
    always_comb begin
        work_d  = work_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        lines_d = lines_q;
        total_d = total_q;
`ifdef LINE_CLEAR_SCORE_EN
        score_d = score_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start_i && !bus.new_game_i) begin
                    work_d  = bus.grid_i;
                    ptr_d   = 5'(ROWS - 1);
                    count_d = 5'd0;
                end
            end
            StScan: begin
                if (!row_full && (ptr_q != 5'd0)) ptr_d = ptr_q - 5'd1;
            end
            StShift: begin
                // Drop row ptr: every row at or above it moves down one; a blank row enters
                // at the top. Rows below ptr and the hidden rows ROWS..21 keep their value.
                work_d[0] = '0;
                for (int k = 1; k < int'(ROWS); k++) begin
                    if (k <= int'(ptr_q)) work_d[k] = work_q[k-1];
                end
                count_d = count_q + 5'd1;
            end
            StWrite: begin
                lines_d = count_q;
                total_d = total_sat;
`ifdef LINE_CLEAR_SCORE_EN
                score_d = score_sat;
`endif
            end
            default: ;
        endcase
        if (bus.new_game_i) begin
            lines_d = 5'd0;
            total_d = '0;
`ifdef LINE_CLEAR_SCORE_EN
            score_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q  <= '0;
            ptr_q   <= 5'd0;
            count_q <= 5'd0;
            lines_q <= 5'd0;
            total_q <= '0;
`ifdef LINE_CLEAR_SCORE_EN
            score_q <= '0;
`endif
        end else begin
            work_q  <= work_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            lines_q <= lines_d;
            total_q <= total_d;
`ifdef LINE_CLEAR_SCORE_EN
            score_q <= score_d;
`endif
        end
    end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl. A grid-level reference model predicts, at start
// accept, the compacted grid, the cleared count k and the write cycle ROWS+2k+1; outputs are
// compared every cycle. Directed cases pin the model with hand-computed literals, followed by
// randomized sequences with stray starts, new-game aborts and resets.
module tb_line_clear_ctrl;

    localparam int ROWS  = 20;
    localparam int COLS  = 10;
    localparam int TOT_W = 4;

    typedef logic [21:0][COLS-1:0] grid_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_clear_ctrl_if #(.COLS(COLS), .TOT_W(TOT_W)) bus ();

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .TOT_W(TOT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit    m_busy;
    int    m_left;
    grid_t m_res;
    int    m_k;
    int    m_lines;
    int    m_total;
    int    m_score;

    // Observation
    int    cyc = 0;
    int    start_cyc = 0;
    int    obs_wcyc;
    grid_t obs_grid;
    int    dones;
    int    busy_cnt;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void compact(input grid_t g, output grid_t r, output int k);
        int dst;
        r   = g;
        k   = 0;
        dst = ROWS - 1;
        for (int src = ROWS - 1; src >= 0; src--) begin
            if (&g[src]) begin
                k++;
            end else begin
                r[dst] = g[src];
                dst--;
            end
        end
        for (int i = 0; i <= dst; i++) r[i] = '0;
    endfunction

    function automatic int pts(input int n);
        if (n == 0) return 0;
        if (n == 1) return 40;
        if (n == 2) return 100;
        if (n == 3) return 300;
        return 1200;
    endfunction

    function automatic grid_t rand_grid();
        grid_t g;
        for (int r = 0; r < 22; r++) begin
            if ($urandom_range(0, 2) == 0) g[r] = '1;
            else g[r] = COLS'($urandom);
        end
        return g;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_left  = 0;
        m_res   = '0;
        m_k     = 0;
        m_lines = 0;
        m_total = 0;
        m_score = 0;
    endtask

    // One clock: drive inputs after the falling edge, compare, then advance the model.
    task automatic cycle(input logic st, input logic ng, input grid_t g);
        logic  e_we;
        grid_t e_grid;
        @(negedge clk);
        bus.start_i    = st;
        bus.new_game_i = ng;
        bus.grid_i     = g;
        #1;
        cyc++;
        e_we   = m_busy && (m_left == 0) && !ng;
        e_grid = e_we ? m_res : '0;
        check("busy_o", 256'(bus.busy_o), 256'(m_busy));
        check("grid_we_o", 256'(bus.grid_we_o), 256'(e_we));
        check("done_o", 256'(bus.done_o), 256'(e_we));
        check("grid_o", 256'(bus.grid_o), 256'(e_grid));
        check("lines_cleared_o", 256'(bus.lines_cleared_o), 256'(m_lines));
        check("total_lines_o", 256'(bus.total_lines_o), 256'(m_total));
`ifdef LINE_CLEAR_SCORE_EN
        check("score_o", 256'(bus.score_o), 256'(m_score));
`endif
        if (bus.busy_o) busy_cnt++;
        if (bus.grid_we_o) begin
            obs_wcyc = cyc - start_cyc;
            obs_grid = bus.grid_o;
            dones++;
        end
        if (ng) begin
            m_busy  = 0;
            m_lines = 0;
            m_total = 0;
            m_score = 0;
        end else if (m_busy) begin
            if (m_left == 0) begin
                m_lines = m_k;
                m_total = m_total + m_k;
                if (m_total > (1 << TOT_W) - 1) m_total = (1 << TOT_W) - 1;
                m_score = m_score + pts(m_k);
                if (m_score > 20'hFFFFF) m_score = 20'hFFFFF;
                m_busy = 0;
            end else begin
                m_left--;
            end
        end else if (st) begin
            compact(g, m_res, m_k);
            m_left    = ROWS + 2 * m_k;
            m_busy    = 1;
            start_cyc = cyc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        bus.start_i    = 1'b0;
        bus.new_game_i = 1'b0;
        #1;
        check("rst busy_o", 256'(bus.busy_o), 256'(0));
        check("rst grid_we_o", 256'(bus.grid_we_o), 256'(0));
        check("rst done_o", 256'(bus.done_o), 256'(0));
        check("rst grid_o", 256'(bus.grid_o), 256'(0));
        check("rst lines_cleared_o", 256'(bus.lines_cleared_o), 256'(0));
        check("rst total_lines_o", 256'(bus.total_lines_o), 256'(0));
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Start a sequence; optionally pulse a second start at relative cycle mid_at.
    task automatic run_seq(input grid_t g, input int mid_at, input grid_t g2);
        obs_wcyc = -1;
        obs_grid = '0;
        dones    = 0;
        busy_cnt = 0;
        cycle(1'b1, 1'b0, g);
        for (int i = 1; i <= 35; i++) cycle(i == mid_at, 1'b0, g2);
    endtask

    task automatic new_game();
        cycle(1'b0, 1'b1, '0);
    endtask

    grid_t g1, g2, g3, g4;
    int    n;

    initial begin
        bus.start_i    = 1'b0;
        bus.new_game_i = 1'b0;
        bus.grid_i     = '0;
        model_reset();
        do_reset();

        // Empty grid
        g1 = '0;
        run_seq(g1, 0, '0);
        check("empty wcyc", 256'(obs_wcyc), 256'(21));
        check("empty grid", 256'(obs_grid), 256'(0));
        check("empty busy cycles", 256'(busy_cnt), 256'(21));
        check("empty lines", 256'(bus.lines_cleared_o), 256'(0));
        check("empty total", 256'(bus.total_lines_o), 256'(0));

        // One full row
        g2 = '0;
        g2[19] = 10'h3FF;
        g2[18] = 10'h201;
        run_seq(g2, 0, '0);
        check("one wcyc", 256'(obs_wcyc), 256'(23));
        check("one row19", 256'(obs_grid[19]), 256'(10'h201));
        check("one rows0-18", 256'(obs_grid[18:0]), 256'(0));
        check("one lines", 256'(bus.lines_cleared_o), 256'(1));

        // Four full rows
        new_game();
        g3 = '0;
        for (int r = 16; r < 20; r++) g3[r] = 10'h3FF;
        g3[15] = 10'h010;
        run_seq(g3, 0, '0);
        check("four wcyc", 256'(obs_wcyc), 256'(29));
        check("four row19", 256'(obs_grid[19]), 256'(10'h010));
        check("four lines", 256'(bus.lines_cleared_o), 256'(4));
        check("four total", 256'(bus.total_lines_o), 256'(4));
`ifdef LINE_CLEAR_SCORE_EN
        check("four score", 256'(bus.score_o), 256'(1200));
`endif

        // Non-adjacent full rows, hidden rows preloaded
        g4 = '0;
        g4[19] = 10'h3FF;
        g4[17] = 10'h3FF;
        g4[18] = 10'h001;
        g4[20] = 10'h155;
        g4[21] = 10'h155;
        run_seq(g4, 0, '0);
        check("gap wcyc", 256'(obs_wcyc), 256'(25));
        check("gap row19", 256'(obs_grid[19]), 256'(10'h001));
        check("gap row20", 256'(obs_grid[20]), 256'(10'h155));
        check("gap row21", 256'(obs_grid[21]), 256'(10'h155));
        check("gap lines", 256'(bus.lines_cleared_o), 256'(2));

        // Reset mid-sequence
        dones = 0;
        cycle(1'b1, 1'b0, g3);
        for (int i = 1; i < 5; i++) cycle(1'b0, 1'b0, '0);
        do_reset();
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, '0);
        check("rst no done", 256'(dones), 256'(0));
        run_seq(g1, 0, '0);
        check("rst restart wcyc", 256'(obs_wcyc), 256'(21));
        check("rst restart dones", 256'(dones), 256'(1));

        // new_game mid-sequence
        run_seq(g2, 0, '0);
        dones = 0;
        cycle(1'b1, 1'b0, g3);
        for (int i = 1; i < 5; i++) cycle(1'b0, 1'b0, '0);
        new_game();
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, '0);
        check("ng no done", 256'(dones), 256'(0));
        check("ng total", 256'(bus.total_lines_o), 256'(0));
        run_seq(g1, 0, '0);
        check("ng restart wcyc", 256'(obs_wcyc), 256'(21));

        // Saturation of the running total, with a stray start mid-scan
        new_game();
        run_seq(g3, 0, '0);
        run_seq(g3, 0, '0);
        run_seq(g3, 0, '0);
        run_seq(g4, 0, '0);
        check("sat pre total", 256'(bus.total_lines_o), 256'(14));
        run_seq(g3, 5, g2);
        check("sat total", 256'(bus.total_lines_o), 256'(15));
        check("sat single done", 256'(dones), 256'(1));
        check("sat wcyc", 256'(obs_wcyc), 256'(29));

        // Randomized sequences
        new_game();
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 19) == 0) do_reset();
            cycle(1'b1, 1'b0, rand_grid());
            n = $urandom_range(5, 70);
            for (int j = 0; j < n; j++) begin
                cycle($urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0, rand_grid());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
